// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of a single ALU between the execute port (0) and the
// address/branch port (1); one operation in flight, result returned via valid/ready.
module alu_share_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ALU_OP_WIDTH   = 4,
    parameter int ALU_COMP_WIDTH = 3,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic [ALU_OP_WIDTH-1:0]   req0_op,
    input  logic [DATA_WIDTH-1:0]     req0_din1,
    input  logic [DATA_WIDTH-1:0]     req0_din2,
    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic [ALU_OP_WIDTH-1:0]   req1_op,
    input  logic [DATA_WIDTH-1:0]     req1_din1,
    input  logic [DATA_WIDTH-1:0]     req1_din2,
    output logic                      rsp0_valid,
    input  logic                      rsp0_ready,
    output logic                      rsp1_valid,
    input  logic                      rsp1_ready,
    output logic [DATA_WIDTH-1:0]     rsp_dout,
    output logic [ALU_COMP_WIDTH-1:0] rsp_comp,
    output logic [ALU_OP_WIDTH-1:0]   alu_op,
    output logic [DATA_WIDTH-1:0]     alu_din1,
    output logic [DATA_WIDTH-1:0]     alu_din2,
    input  logic [DATA_WIDTH-1:0]     alu_dout,
    input  logic [ALU_COMP_WIDTH-1:0] alu_comp,
    output logic                      busy,
    output logic [CNT_WIDTH-1:0]      op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                    state_reg, state_next;
    logic                      ptr_reg, ptr_next;
    logic                      owner_reg, owner_next;
    logic [ALU_OP_WIDTH-1:0]   op_reg, op_next;
    logic [DATA_WIDTH-1:0]     din1_reg, din1_next;
    logic [DATA_WIDTH-1:0]     din2_reg, din2_next;
    logic [DATA_WIDTH-1:0]     dout_reg, dout_next;
    logic [ALU_COMP_WIDTH-1:0] comp_reg, comp_next;
    logic [CNT_WIDTH-1:0]      count_reg, count_next;

    logic grant_any;
    logic grant_id;
    logic owner_rsp_ready;

    // With both requesters valid, ptr_reg names the port that did not win last.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        grant_id  = (req0_valid & req1_valid) ? ptr_reg : req1_valid;
    end

    assign req0_ready      = (state_reg == IDLE) && grant_any && !grant_id;
    assign req1_ready      = (state_reg == IDLE) && grant_any && grant_id;
    assign owner_rsp_ready = owner_reg ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        owner_next = owner_reg;
        op_next    = op_reg;
        din1_next  = din1_reg;
        din2_next  = din2_reg;
        dout_next  = dout_reg;
        comp_next  = comp_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                if (grant_any) begin
                    owner_next = grant_id;
                    ptr_next   = ~grant_id;
                    op_next    = grant_id ? req1_op   : req0_op;
                    din1_next  = grant_id ? req1_din1 : req0_din1;
                    din2_next  = grant_id ? req1_din2 : req0_din2;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                dout_next  = alu_dout;
                comp_next  = alu_comp;
                state_next = RESP;
            end
            RESP: begin
                if (owner_rsp_ready) begin
                    state_next = IDLE;
                    if (count_reg != {CNT_WIDTH{1'b1}}) begin
                        count_next = count_reg + CNT_ONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            ptr_reg   <= 1'b0;
            owner_reg <= 1'b0;
            op_reg    <= '0;
            din1_reg  <= '0;
            din2_reg  <= '0;
            dout_reg  <= '0;
            comp_reg  <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            owner_reg <= owner_next;
            op_reg    <= op_next;
            din1_reg  <= din1_next;
            din2_reg  <= din2_next;
            dout_reg  <= dout_next;
            comp_reg  <= comp_next;
            count_reg <= count_next;
        end
    end

    // The ALU only sees live operands during EXEC; it idles on nop otherwise.
    assign alu_op     = (state_reg == EXEC) ? op_reg   : '0;
    assign alu_din1   = (state_reg == EXEC) ? din1_reg : '0;
    assign alu_din2   = (state_reg == EXEC) ? din2_reg : '0;
    assign rsp0_valid = (state_reg == RESP) && !owner_reg;
    assign rsp1_valid = (state_reg == RESP) && owner_reg;
    assign rsp_dout   = dout_reg;
    assign rsp_comp   = comp_reg;
    assign busy       = (state_reg != IDLE);
    assign op_count   = count_reg;

endmodule
